snake_body_ctrl: RTL and testbench
==================================

# snake_body_ctrl

Snake movement and body-storage stage of the greedy-snake game. It sits directly upstream of the apple/eat logic: it produces the head coordinate that block compares against the apple, and it consumes that block's `add_cube` grow request. On each game step it advances the snake one cell in the latched direction, grows the body on request, and detects wall and self collisions. It also answers a per-cell occupancy query for the VGA renderer.

## Interface
- `MAX_LEN`, default 16: maximum number of body segments, head included.
- `STEP_CYCLES`, default 250_000: clock cycles per game step.
- `X_MAX`, default 62: largest legal x; legal x range is 1..X_MAX.
- `Y_MAX`, default 52: largest legal y; legal y range is 1..Y_MAX.

- `clk` in 1: system clock. The block uses one clock domain only.
- `rst` in 1: reset, synchronous and active-high.
- `dir_req` in 4: one-hot direction request, bit order {up, down, left, right}. Each bit is a debounced one-cycle pulse.
- `add_cube` in 1: grow request from the apple logic. It is level-type and may stay high for many cycles.
- `query_x`, `query_y` in 7 each: cell to test for occupancy.
- `query_hit` out 1: the queried cell holds a body segment. Registered.
- `query_head` out 1: the queried cell is the head. Registered.
- `head_x`, `head_y` out 7 each: current head coordinate.
- `length` out 5: current segment count, range 3..MAX_LEN.
- `step` out 1: one-cycle pulse on the cycle a move commits.
- `game_over` out 1: high while in state OVER.

## Operation
- **Storage:** `seg_x[i]`, `seg_y[i]` for i = 0..MAX_LEN-1; i = 0 is the head. Only indices below `length` are valid. Invalid entries hold (0,0), a wall cell that never matches a legal coordinate.
- **States:** START, RUN, OVER.
  - START: the snake is drawn but does not move. Any accepted `dir_req` moves to RUN.
  - RUN: the snake moves on every tick.
  - OVER: everything is frozen. Only `rst` leaves this state.
- **Reset values:**
  - state START, `cur_dir` = `next_dir` = RIGHT.
  - Segments: (10,30), (9,30), (8,30); all others (0,0).
  - `length` = 3, grow_pending = 0, tick counter = 0.
  - Outputs: `head_x` = 10, `head_y` = 30, `step` = 0, `game_over` = 0, `query_hit` = 0, `query_head` = 0.
- **Direction:** a `dir_req` is accepted only if exactly one bit is set and it is not the reverse of `cur_dir`. An accepted request is written to `next_dir`; later accepted requests before a step overwrite it. `next_dir` is copied to `cur_dir` only at a step. Two quick presses between steps therefore cannot produce a reversal.
- **Tick:** the counter runs freely 0..STEP_CYCLES-1 in every state. The cycle where it equals STEP_CYCLES-1 is the tick; a step happens on that tick only in RUN.
- **Step:**
  1. Compute the new head nh = head + `next_dir` (x+1 for right, x-1 for left, y-1 for up, y+1 for down). Compute this in 8 bits so that 0 and overflow are caught.
  2. Wall hit: nh.x equal to 0 or greater than X_MAX, or nh.y equal to 0 or greater than Y_MAX.
  3. Self hit: nh equals `seg[i]` for any i < `length`-1. When growing, the range is i < `length` instead, because the tail does not vacate.
  4. On either hit: go to OVER. Nothing moves, and no `step` pulse is issued.
  5. Otherwise: shift `seg[i]` ← `seg[i-1]` and set `seg[0]` ← nh.
  6. If grow_pending and `length` < MAX_LEN: increment `length`; the old tail stays as the new last segment.
  7. Clear grow_pending on every committed step. At MAX_LEN the request is dropped.
- **Grow request:** grow_pending is set on a rising edge of `add_cube`, detected against a registered copy. A long high level therefore counts once. A rising edge on the same cycle as a step sets grow_pending for the following step, not the current one.
- **Query:** `query_hit` compares against all valid segments; `query_head` compares against `seg[0]` only.

## Timing
- `head_x`, `head_y` and `length` update on the clock edge of the step cycle, so they are visible the cycle after the tick. `step` is high for exactly that one cycle.
- `query_hit` and `query_head` have 1-cycle latency from `query_x`/`query_y`, and they reflect the segment state at sampling time.
- START→RUN happens the cycle after an accepted `dir_req`. The first move occurs at the next tick.
- The state enters OVER at the tick edge; `game_over` rises the cycle after the tick.
- `rst` asserted in any state and mid-step restores all reset values on the next edge. Reset has priority over step, grow and direction updates.

## Test plan
Bench parameter: STEP_CYCLES = 4.

- **Start and right move:** after reset, check head (10,30), `length` 3, no motion for 20 cycles. Pulse `dir_req` right → RUN; at the next tick `step` pulses and the head is (11,30). Segments 1 and 2 are (10,30) and (9,30).
- **Reversal and double-press:** in RUN heading right, pulse left → ignored, so the next step goes to x+1. Then pulse up, then left, within one tick → the move is up (y-1); left is rejected because `cur_dir` is still right when evaluated, and not reverse of up only after the commit.
- **Grow:** hold `add_cube` high for 10 cycles → exactly one growth. At the next step `length` is 4 and the old tail is kept. Repeat until `length` is 16; a further `add_cube` edge leaves `length` at 16 with no error.
- **Wall:** steer up from y = 30 → on the step that would reach y = 0, `game_over` = 1, the head stays (x,1) and `step` stays 0. Further ticks and `dir_req` have no effect.
- **Self collision:** with `length` 5, issue right, down, left, up in successive steps → `game_over` on the fourth step. With `length` 4, the same loop is legal because the tail vacates.
- **Query and reset:** query (9,30) after reset → `query_hit` = 1 and `query_head` = 0 one cycle later; query (10,30) → `query_head` = 1. Assert `rst` in OVER → all reset values next cycle.

Source files
------------

// File: rtl/snake_body_ctrl.sv
// rtl/snake_body_ctrl.sv - snake movement, growth, collision detection and cell occupancy query
module snake_body_ctrl #(
  parameter int MAX_LEN     = 16,
  parameter int STEP_CYCLES = 250_000,
  parameter int X_MAX       = 62,
  parameter int Y_MAX       = 52
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] dir_req,
  input  logic       add_cube,
  input  logic [6:0] query_x,
  input  logic [6:0] query_y,
  output logic       query_hit,
  output logic       query_head,
  output logic [6:0] head_x,
  output logic [6:0] head_y,
  output logic [4:0] length,
  output logic       step,
  output logic       game_over
);

  localparam int               CNT_W     = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STEP_CYCLES - 1);
  localparam logic [4:0]       LEN_MAX   = 5'(MAX_LEN);
  localparam logic [3:0]       DIR_UP    = 4'b1000;
  localparam logic [3:0]       DIR_DOWN  = 4'b0100;
  localparam logic [3:0]       DIR_LEFT  = 4'b0010;
  localparam logic [3:0]       DIR_RIGHT = 4'b0001;

  typedef enum logic [1:0] {START, RUN, OVER} state_t;

  state_t           state_q, state_d;
  logic [3:0]       cur_dir_q, cur_dir_d;
  logic [3:0]       next_dir_q, next_dir_d;
  logic [6:0]       seg_x_q [MAX_LEN];
  logic [6:0]       seg_x_d [MAX_LEN];
  logic [6:0]       seg_y_q [MAX_LEN];
  logic [6:0]       seg_y_d [MAX_LEN];
  logic [4:0]       length_q, length_d;
  logic             grow_pending_q, grow_pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             add_cube_q, add_cube_d;
  logic             step_q, step_d;
  logic             query_hit_q, query_hit_d;
  logic             query_head_q, query_head_d;

  logic             tick, step_cycle, dir_onehot, dir_ok, cube_rise;
  logic             wall_hit, self_hit, grow, move;
  logic [7:0]       nh_x, nh_y;
  logic [4:0]       check_len;

  function automatic logic [3:0] reverse_of(input logic [3:0] d);
    return {d[2], d[3], d[0], d[1]};
  endfunction

  // Tick counter, direction filter, new-head evaluation and body shift
  always_comb begin
    state_d        = state_q;
    cur_dir_d      = cur_dir_q;
    next_dir_d     = next_dir_q;
    seg_x_d        = seg_x_q;
    seg_y_d        = seg_y_q;
    length_d       = length_q;
    grow_pending_d = grow_pending_q;
    add_cube_d     = add_cube;

    tick       = (cnt_q == CNT_LAST);
    cnt_d      = tick ? '0 : cnt_q + CNT_W'(1);
    step_cycle = (state_q == RUN) && tick;
    cube_rise  = add_cube && !add_cube_q;

    // On a step edge next_dir becomes cur_dir, so a request landing there must not reverse it either
    dir_onehot = (dir_req != 4'b0000) && ((dir_req & (dir_req - 4'd1)) == 4'b0000);
    dir_ok     = dir_onehot && (dir_req != reverse_of(cur_dir_q)) &&
                 !(step_cycle && (dir_req == reverse_of(next_dir_q)));

    // 8-bit arithmetic so that stepping off either edge is visible as 0 or > MAX
    nh_x = {1'b0, seg_x_q[0]};
    nh_y = {1'b0, seg_y_q[0]};
    case (next_dir_q)
      DIR_UP:   nh_y = nh_y - 8'd1;
      DIR_DOWN: nh_y = nh_y + 8'd1;
      DIR_LEFT: nh_x = nh_x - 8'd1;
      default:  nh_x = nh_x + 8'd1;
    endcase
    wall_hit = (nh_x == 8'd0) || (nh_x > 8'(X_MAX)) || (nh_y == 8'd0) || (nh_y > 8'(Y_MAX));

    // The tail only vacates its cell when the snake is not growing on this step
    grow      = grow_pending_q && (length_q < LEN_MAX);
    check_len = grow ? length_q : length_q - 5'd1;
    self_hit  = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < check_len) && ({1'b0, seg_x_q[i]} == nh_x) && ({1'b0, seg_y_q[i]} == nh_y)) begin
        self_hit = 1'b1;
      end
    end

    move   = step_cycle && !wall_hit && !self_hit;
    step_d = move;

    case (state_q)
      START: begin
        if (dir_ok) begin
          next_dir_d = dir_req;
          state_d    = RUN;
        end
        if (cube_rise) grow_pending_d = 1'b1;
      end
      RUN: begin
        if (dir_ok) next_dir_d = dir_req;
        if (step_cycle && (wall_hit || self_hit)) begin
          state_d = OVER;
        end else if (move) begin
          cur_dir_d      = next_dir_q;
          length_d       = grow ? length_q + 5'd1 : length_q;
          // An edge on the step cycle itself belongs to the following step
          grow_pending_d = cube_rise;
          seg_x_d[0]     = nh_x[6:0];
          seg_y_d[0]     = nh_y[6:0];
          for (int i = 1; i < MAX_LEN; i++) begin
            seg_x_d[i] = (5'(i) < length_d) ? seg_x_q[i-1] : 7'd0;
            seg_y_d[i] = (5'(i) < length_d) ? seg_y_q[i-1] : 7'd0;
          end
        end else if (cube_rise) begin
          grow_pending_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Occupancy lookup against the current (pre-edge) body
  always_comb begin
    query_hit_d = 1'b0;
    for (int i = 0; i < MAX_LEN; i++) begin
      if ((5'(i) < length_q) && (seg_x_q[i] == query_x) && (seg_y_q[i] == query_y)) begin
        query_hit_d = 1'b1;
      end
    end
    query_head_d = (seg_x_q[0] == query_x) && (seg_y_q[0] == query_y);
  end

  // State registers with synchronous reset to the initial three-segment snake
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= START;
      cur_dir_q      <= DIR_RIGHT;
      next_dir_q     <= DIR_RIGHT;
      length_q       <= 5'd3;
      grow_pending_q <= 1'b0;
      cnt_q          <= '0;
      add_cube_q     <= 1'b0;
      step_q         <= 1'b0;
      query_hit_q    <= 1'b0;
      query_head_q   <= 1'b0;
      for (int i = 0; i < MAX_LEN; i++) begin
        seg_x_q[i] <= (i < 3) ? 7'(10 - i) : 7'd0;
        seg_y_q[i] <= (i < 3) ? 7'd30 : 7'd0;
      end
    end else begin
      state_q        <= state_d;
      cur_dir_q      <= cur_dir_d;
      next_dir_q     <= next_dir_d;
      length_q       <= length_d;
      grow_pending_q <= grow_pending_d;
      cnt_q          <= cnt_d;
      add_cube_q     <= add_cube_d;
      step_q         <= step_d;
      query_hit_q    <= query_hit_d;
      query_head_q   <= query_head_d;
      seg_x_q        <= seg_x_d;
      seg_y_q        <= seg_y_d;
    end
  end

  assign head_x     = seg_x_q[0];
  assign head_y     = seg_y_q[0];
  assign length     = length_q;
  assign step       = step_q;
  assign game_over  = (state_q == OVER);
  assign query_hit  = query_hit_q;
  assign query_head = query_head_q;

endmodule

// File: tb/tb_snake_body_ctrl.sv
// tb/tb_snake_body_ctrl.sv - scoreboard bench for snake_body_ctrl
module tb_snake_body_ctrl;

  localparam logic [3:0] NONE  = 4'b0000;
  localparam logic [3:0] UP    = 4'b1000;
  localparam logic [3:0] DOWN  = 4'b0100;
  localparam logic [3:0] LEFT  = 4'b0010;
  localparam logic [3:0] RIGHT = 4'b0001;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] dir_req;
  logic       add_cube;
  logic [6:0] query_x, query_y;
  logic       query_hit, query_head;
  logic [6:0] head_x, head_y;
  logic [4:0] length;
  logic       step, game_over;

  always #5 clk = ~clk;

  snake_body_ctrl #(
    .MAX_LEN(16), .STEP_CYCLES(4), .X_MAX(62), .Y_MAX(52)
  ) dut (
    .clk(clk), .rst(rst), .dir_req(dir_req), .add_cube(add_cube),
    .query_x(query_x), .query_y(query_y), .query_hit(query_hit), .query_head(query_head),
    .head_x(head_x), .head_y(head_y), .length(length), .step(step), .game_over(game_over)
  );

  typedef struct { int x; int y; int len; } step_exp_t;
  typedef struct { bit hit; bit head; } query_exp_t;

  step_exp_t  step_sb[$];
  query_exp_t query_sb[$];
  step_exp_t  sexp;
  query_exp_t qexp;
  int total = 0;
  int bad = 0;
  int step_cnt = 0;
  bit seen;

  always @(posedge clk) if (step === 1'b1) step_cnt <= step_cnt + 1;

  task automatic drive_step(input logic [3:0] d1, input logic [3:0] d2, input bit g,
                            input int ex, input int ey, input int el, output bit got);
    step_exp_t e;
    int waited;
    e.x = ex; e.y = ey; e.len = el;
    step_sb.push_back(e);
    dir_req = d1;
    if (g) add_cube = 1'b1;
    @(negedge clk);
    dir_req = d2;
    if (g) add_cube = 1'b0;
    waited = 0;
    while (step !== 1'b1 && waited < 12) begin
      @(negedge clk);
      dir_req = NONE;
      waited++;
    end
    dir_req = NONE;
    got = (step === 1'b1);
  endtask

  task automatic drive_query(input int qx, input int qy, input bit eh, input bit ehd);
    query_exp_t e;
    e.hit = eh; e.head = ehd;
    query_sb.push_back(e);
    query_x = 7'(qx);
    query_y = 7'(qy);
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1; dir_req = NONE; add_cube = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    step_sb.delete();
    query_sb.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1; dir_req = NONE; add_cube = 1'b0; query_x = 7'd10; query_y = 7'd30;
    repeat (2) @(negedge clk);
    total++;
    if (head_x !== 7'd10 || head_y !== 7'd30) begin
      bad++; $display("FAIL reset_head: got (%0d,%0d) want (10,30)", head_x, head_y);
    end
    total++;
    if (length !== 5'd3) begin
      bad++; $display("FAIL reset_length: got %0d want 3", length);
    end
    total++;
    if (step !== 1'b0 || game_over !== 1'b0) begin
      bad++; $display("FAIL reset_flags: step=%b game_over=%b want 0 0", step, game_over);
    end
    total++;
    if (query_hit !== 1'b0 || query_head !== 1'b0) begin
      bad++; $display("FAIL reset_query: hit=%b head=%b want 0 0", query_hit, query_head);
    end
    rst = 1'b0;
    step_sb.delete();
    query_sb.delete();
  endtask

  task automatic test_start_idle();
    int c0;
    c0 = step_cnt;
    repeat (20) @(negedge clk);
    total++;
    if (step_cnt !== c0 || head_x !== 7'd10 || head_y !== 7'd30 || game_over !== 1'b0) begin
      bad++; $display("FAIL start_idle: steps=%0d head=(%0d,%0d) go=%b want 0 (10,30) 0",
                      step_cnt - c0, head_x, head_y, game_over);
    end
  endtask

  task automatic test_right_move();
    drive_step(RIGHT, NONE, 1'b0, 11, 30, 3, seen);
    sexp = step_sb.pop_front();
    total++;
    if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
      bad++; $display("FAIL right_step: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                      seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
    end
    for (int i = 0; i < 2; i++) begin
      drive_query(10 - i, 30, 1'b1, 1'b0);
      qexp = query_sb.pop_front();
      total++;
      if (query_hit !== qexp.hit || query_head !== qexp.head) begin
        bad++; $display("FAIL right_seg%0d: hit=%b head=%b want %b %b",
                        i + 1, query_hit, query_head, qexp.hit, qexp.head);
      end
    end
  endtask

  task automatic test_reverse();
    logic [3:0] d1 [3] = '{LEFT, UP, NONE};
    logic [3:0] d2 [3] = '{NONE, LEFT, NONE};
    int         ey [3] = '{30, 29, 28};
    for (int i = 0; i < 3; i++) begin
      drive_step(d1[i], d2[i], 1'b0, 12, ey[i], 3, seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL reverse_%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        i, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
      if (i == 0) begin
        drive_query(9, 30, 1'b0, 1'b0);
        qexp = query_sb.pop_front();
        total++;
        if (query_hit !== qexp.hit || query_head !== qexp.head) begin
          bad++; $display("FAIL tail_vacated: hit=%b head=%b want %b %b",
                          query_hit, query_head, qexp.hit, qexp.head);
        end
      end
    end
  endtask

  task automatic test_grow();
    add_cube = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive_step(NONE, NONE, 1'b0, 12, 27 - k, 4, seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL grow_level_%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        k, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
      if (k == 0) begin
        drive_query(12, 30, 1'b1, 1'b0);
        qexp = query_sb.pop_front();
        total++;
        if (query_hit !== qexp.hit || query_head !== qexp.head) begin
          bad++; $display("FAIL grow_tail_kept: hit=%b head=%b want %b %b",
                          query_hit, query_head, qexp.hit, qexp.head);
        end
      end
    end
    add_cube = 1'b0;
    drive_query(12, 29, 1'b0, 1'b0);
    qexp = query_sb.pop_front();
    total++;
    if (query_hit !== qexp.hit || query_head !== qexp.head) begin
      bad++; $display("FAIL grow_tail_moved: hit=%b head=%b want %b %b",
                      query_hit, query_head, qexp.hit, qexp.head);
    end
    for (int k = 0; k < 14; k++) begin
      drive_step(NONE, NONE, (k < 13), 12, 24 - k, (k < 12) ? 5 + k : 16, seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL grow_fill_%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        k, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
    end
  endtask

  task automatic test_wall();
    int c0;
    int waited;
    for (int y = 10; y >= 1; y--) begin
      drive_step(NONE, NONE, 1'b0, 12, y, 16, seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL wall_approach_y%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        y, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
    end
    @(negedge clk);
    c0 = step_cnt;
    waited = 0;
    while (game_over !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (game_over !== 1'b1) begin
      bad++; $display("FAIL wall_game_over: game_over=%b want 1", game_over);
    end
    total++;
    if (head_x !== 7'd12 || head_y !== 7'd1 || length !== 5'd16 || step_cnt !== c0) begin
      bad++; $display("FAIL wall_no_move: head (%0d,%0d) len %0d steps %0d want (12,1) 16 0",
                      head_x, head_y, length, step_cnt - c0);
    end
    dir_req = RIGHT; add_cube = 1'b1;
    @(negedge clk);
    dir_req = NONE; add_cube = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (head_x !== 7'd12 || head_y !== 7'd1 || length !== 5'd16 || step_cnt !== c0 || game_over !== 1'b1) begin
      bad++; $display("FAIL wall_frozen: head (%0d,%0d) len %0d steps %0d go %b want (12,1) 16 0 1",
                      head_x, head_y, length, step_cnt - c0, game_over);
    end
  endtask

  task automatic test_self_collision();
    logic [3:0] d4 [5] = '{RIGHT, RIGHT, DOWN, LEFT, UP};
    bit         g4 [5] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    int         x4 [5] = '{11, 12, 12, 11, 11};
    int         y4 [5] = '{30, 30, 31, 31, 30};
    logic [3:0] d5 [5] = '{RIGHT, NONE, RIGHT, DOWN, LEFT};
    bit         g5 [5] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    int         x5 [5] = '{11, 12, 13, 13, 12};
    int         y5 [5] = '{30, 30, 30, 31, 31};
    int         l5 [5] = '{4, 5, 5, 5, 5};
    int c0;
    int waited;
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_step(d4[i], NONE, g4[i], x4[i], y4[i], 4, seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL loop_len4_%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        i, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
    end
    total++;
    if (game_over !== 1'b0) begin
      bad++; $display("FAIL loop_len4_legal: game_over=%b want 0", game_over);
    end
    apply_reset();
    for (int i = 0; i < 5; i++) begin
      drive_step(d5[i], NONE, g5[i], x5[i], y5[i], l5[i], seen);
      sexp = step_sb.pop_front();
      total++;
      if (!seen || head_x !== 7'(sexp.x) || head_y !== 7'(sexp.y) || length !== 5'(sexp.len)) begin
        bad++; $display("FAIL loop_len5_%0d: seen=%b got (%0d,%0d) len %0d want (%0d,%0d) len %0d",
                        i, seen, head_x, head_y, length, sexp.x, sexp.y, sexp.len);
      end
    end
    dir_req = UP;
    @(negedge clk);
    dir_req = NONE;
    c0 = step_cnt;
    waited = 0;
    while (game_over !== 1'b1 && waited < 10) begin
      @(negedge clk);
      waited++;
    end
    total++;
    if (game_over !== 1'b1 || step_cnt !== c0) begin
      bad++; $display("FAIL self_hit: game_over=%b steps=%0d want 1 0", game_over, step_cnt - c0);
    end
    total++;
    if (head_x !== 7'd12 || head_y !== 7'd31 || length !== 5'd5) begin
      bad++; $display("FAIL self_hit_frozen: head (%0d,%0d) len %0d want (12,31) 5", head_x, head_y, length);
    end
  endtask

  task automatic test_query_reset();
    int qx [4] = '{9, 10, 8, 7};
    bit qh [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    bit qd [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    drive_query(12, 31, 1'b1, 1'b1);
    qexp = query_sb.pop_front();
    total++;
    if (query_hit !== qexp.hit || query_head !== qexp.head) begin
      bad++; $display("FAIL over_query: hit=%b head=%b want %b %b", query_hit, query_head, qexp.hit, qexp.head);
    end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (head_x !== 7'd10 || head_y !== 7'd30 || length !== 5'd3 || game_over !== 1'b0 ||
        step !== 1'b0 || query_hit !== 1'b0 || query_head !== 1'b0) begin
      bad++; $display("FAIL over_reset: head (%0d,%0d) len %0d go %b step %b q %b%b want (10,30) 3 0 0 00",
                      head_x, head_y, length, game_over, step, query_hit, query_head);
    end
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      drive_query(qx[i], 30, qh[i], qd[i]);
      qexp = query_sb.pop_front();
      total++;
      if (query_hit !== qexp.hit || query_head !== qexp.head) begin
        bad++; $display("FAIL query_%0d_30: hit=%b head=%b want %b %b",
                        qx[i], query_hit, query_head, qexp.hit, qexp.head);
      end
    end
  endtask

  initial begin
    rst = 1'b1; dir_req = NONE; add_cube = 1'b0; query_x = 7'd0; query_y = 7'd0;
    test_reset();
    test_start_idle();
    test_right_move();
    test_reverse();
    test_grow();
    test_wall();
    test_self_collision();
    test_query_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
